fdivsqrt_arbiter: RTL and testbench

Shares the single combined divide/square-root unit between two requesters: the integer divide/remainder path (port I) and the floating-point divide/sqrt path (port F). The block accepts operations over valid/ready handshakes and latches their operands and tag. It sequences the shared unit with start/busy/done signals and returns the result to the owning requester over a valid/ready response channel. It sits in the execute stage between the issue logic and the divsqrt unit, and handles pipeline flushes of in-flight work.

---
 rtl/fdivsqrt_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_fdivsqrt_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdivsqrt_arbiter.sv
// Purpose: shares one divide/sqrt unit between the integer (I) and FP (F) requesters.
// Latency: accept -> unit_start is 1 cycle; unit_done -> rsp_valid is 1 cycle.
// Backpressure: one op in flight; no request is accepted until the response is taken or flushed.
//
// Ports:
//   clk, reset                   clock, async active-low reset
//   i_valid/i_ready/i_op/i_tag   integer request channel
//   f_valid/f_ready/f_op/f_tag   FP request channel
//   flush                        kills all accepted, unreturned work
//   unit_start/isint/op/flush    control and operands towards the divsqrt unit
//   unit_busy/done/result        status and result from the divsqrt unit
//   rsp_valid/ready/isint/tag/result  response channel back to the owner
//   wdog_err                     sticky unit-timeout flag
module fdivsqrt_arbiter #(
  parameter int XLEN = 64,
  parameter int OPW  = 2*XLEN+8,
  parameter int RESW = XLEN+8,
  parameter int TAGW = 5,
  parameter int TOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic [OPW-1:0]  i_op,
  input  logic [TAGW-1:0] i_tag,
  input  logic            f_valid,
  output logic            f_ready,
  input  logic [OPW-1:0]  f_op,
  input  logic [TAGW-1:0] f_tag,
  input  logic            flush,
  output logic            unit_start,
  output logic            unit_isint,
  output logic [OPW-1:0]  unit_op,
  input  logic            unit_busy,
  input  logic            unit_done,
  input  logic [RESW-1:0] unit_result,
  output logic            unit_flush,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_isint,
  output logic [TAGW-1:0] rsp_tag,
  output logic [RESW-1:0] rsp_result,
  output logic            wdog_err
);

  localparam int CW = $clog2(TOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_BUSY  = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic            isint_q, isint_d;
  // 1 = F was granted last, so I wins the next tie.
  logic            rr_last_q, rr_last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wdog_err_q, wdog_err_d;
  logic [RESW-1:0] result_q, result_d;

  logic            grant_i, grant_f;
  logic            start_c, uflush_c;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    tag_d      = tag_q;
    isint_d    = isint_q;
    rr_last_d  = rr_last_q;
    cnt_d      = cnt_q;
    wdog_err_d = wdog_err_q;
    result_d   = result_q;
    grant_i    = 1'b0;
    grant_f    = 1'b0;
    start_c    = 1'b0;
    uflush_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!flush) begin
          if (i_valid && (!f_valid || rr_last_q)) begin
            grant_i = 1'b1;
          end else if (f_valid) begin
            grant_f = 1'b1;
          end
        end
        if (grant_i) begin
          op_d      = i_op;
          tag_d     = i_tag;
          isint_d   = 1'b1;
          rr_last_d = 1'b0;
          state_d   = S_ISSUE;
        end else if (grant_f) begin
          op_d      = f_op;
          tag_d     = f_tag;
          isint_d   = 1'b0;
          rr_last_d = 1'b1;
          state_d   = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          start_c = 1'b1;
          cnt_d   = '0;
          // A unit that completes in its start cycle is still captured.
          if (unit_done) begin
            result_d = unit_result;
            state_d  = S_RESP;
          end else begin
            state_d = S_BUSY;
          end
        end
      end

      S_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (flush) begin
          // Flush beats a same-cycle unit_done: the result is dropped.
          uflush_c = 1'b1;
          state_d  = S_DRAIN;
        end else if (unit_done) begin
          result_d = unit_result;
          state_d  = S_RESP;
        end else if (cnt_q == CW'(TOUT - 1)) begin
          // This is the TOUT-th cycle spent in BUSY.
          wdog_err_d = 1'b1;
          uflush_c   = 1'b1;
          state_d    = S_DRAIN;
        end
      end

      S_RESP: begin
        if (flush || rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      S_DRAIN: begin
        uflush_c = 1'b1;
        // Any unit_done arriving here belongs to killed work and is ignored.
        if (!flush && !unit_busy && !unit_done) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      tag_q      <= '0;
      isint_q    <= 1'b0;
      rr_last_q  <= 1'b1;
      cnt_q      <= '0;
      wdog_err_q <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      tag_q      <= tag_d;
      isint_q    <= isint_d;
      rr_last_q  <= rr_last_d;
      cnt_q      <= cnt_d;
      wdog_err_q <= wdog_err_d;
      result_q   <= result_d;
    end
  end

  // Ready is the grant itself; gating with reset keeps it low while reset is held.
  assign i_ready    = grant_i & reset;
  assign f_ready    = grant_f & reset;
  assign unit_start = start_c;
  assign unit_flush = uflush_c;
  assign unit_isint = isint_q;
  assign unit_op    = op_q;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_isint  = isint_q;
  assign rsp_tag    = tag_q;
  assign rsp_result = result_q;
  assign wdog_err   = wdog_err_q;

endmodule

// File: tb/tb_fdivsqrt_arbiter.sv
`timescale 1ns/1ps
module tb_fdivsqrt_arbiter;

  localparam int XLEN = 64;
  localparam int OPW  = 2*XLEN+8;
  localparam int RESW = XLEN+8;
  localparam int TAGW = 5;

  logic clk = 1'b0;
  logic reset;
  logic i_valid, f_valid, flush, unit_busy, unit_done, rsp_ready;
  logic [OPW-1:0]  i_op, f_op;
  logic [TAGW-1:0] i_tag, f_tag;
  logic [RESW-1:0] unit_result;

  logic i_ready, f_ready, unit_start, unit_isint, unit_flush, rsp_valid, rsp_isint, wdog_err;
  logic [OPW-1:0]  unit_op;
  logic [TAGW-1:0] rsp_tag;
  logic [RESW-1:0] rsp_result;

  logic wd_i_ready, wd_f_ready, wd_unit_start, wd_unit_isint, wd_unit_flush;
  logic wd_rsp_valid, wd_rsp_isint, wd_wdog_err;
  logic [OPW-1:0]  wd_unit_op;
  logic [TAGW-1:0] wd_rsp_tag;
  logic [RESW-1:0] wd_rsp_result;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  fdivsqrt_arbiter #(.XLEN(XLEN), .TAGW(TAGW), .TOUT(255)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_ready(i_ready), .i_op(i_op), .i_tag(i_tag),
    .f_valid(f_valid), .f_ready(f_ready), .f_op(f_op), .f_tag(f_tag),
    .flush(flush),
    .unit_start(unit_start), .unit_isint(unit_isint), .unit_op(unit_op),
    .unit_busy(unit_busy), .unit_done(unit_done), .unit_result(unit_result),
    .unit_flush(unit_flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_isint(rsp_isint),
    .rsp_tag(rsp_tag), .rsp_result(rsp_result), .wdog_err(wdog_err)
  );

  // Short-timeout instance, driven by the same stimulus.
  fdivsqrt_arbiter #(.XLEN(XLEN), .TAGW(TAGW), .TOUT(15)) dut_wd (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_ready(wd_i_ready), .i_op(i_op), .i_tag(i_tag),
    .f_valid(f_valid), .f_ready(wd_f_ready), .f_op(f_op), .f_tag(f_tag),
    .flush(flush),
    .unit_start(wd_unit_start), .unit_isint(wd_unit_isint), .unit_op(wd_unit_op),
    .unit_busy(unit_busy), .unit_done(unit_done), .unit_result(unit_result),
    .unit_flush(wd_unit_flush),
    .rsp_valid(wd_rsp_valid), .rsp_ready(rsp_ready), .rsp_isint(wd_rsp_isint),
    .rsp_tag(wd_rsp_tag), .rsp_result(wd_rsp_result), .wdog_err(wd_wdog_err)
  );

  typedef struct packed {
    logic iv;
    logic fv;
    logic fl;
    logic exp_ir;
    logic exp_fr;
  } vec_t;

  vec_t vecs [0:5];

  task automatic chk(input string nm, input logic [OPW-1:0] act, input logic [OPW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  logic [OPW-1:0] op_a, op_b, op_c;

  initial begin
    vecs[0] = '{iv:1'b0, fv:1'b0, fl:1'b0, exp_ir:1'b0, exp_fr:1'b0};
    vecs[1] = '{iv:1'b1, fv:1'b0, fl:1'b0, exp_ir:1'b1, exp_fr:1'b0};
    vecs[2] = '{iv:1'b0, fv:1'b1, fl:1'b0, exp_ir:1'b0, exp_fr:1'b1};
    vecs[3] = '{iv:1'b1, fv:1'b1, fl:1'b0, exp_ir:1'b1, exp_fr:1'b0};
    vecs[4] = '{iv:1'b1, fv:1'b1, fl:1'b1, exp_ir:1'b0, exp_fr:1'b0};
    vecs[5] = '{iv:1'b0, fv:1'b1, fl:1'b1, exp_ir:1'b0, exp_fr:1'b0};

    op_a = {8'hA5, 64'h0000_0000_0000_0054, 64'h0000_0000_0000_0002};
    op_b = {8'h3C, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
    op_c = {8'h0F, 64'hDEAD_BEEF_0000_0001, 64'h0000_0000_0000_0009};

    reset = 1'b0;
    i_valid = 1'b0; f_valid = 1'b0; flush = 1'b0;
    unit_busy = 1'b0; unit_done = 1'b0; rsp_ready = 1'b0;
    i_op = op_a; f_op = op_b; i_tag = '0; f_tag = '0; unit_result = '0;

    // Reset state: outputs low even with requests pending.
    #2;
    i_valid = 1'b1; f_valid = 1'b1;
    #1;
    chk("rst_i_ready", i_ready, 0);
    chk("rst_f_ready", f_ready, 0);
    chk("rst_unit_start", unit_start, 0);
    chk("rst_unit_flush", unit_flush, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_unit_op", unit_op, 0);
    chk("rst_wdog_err", wdog_err, 0);
    i_valid = 1'b0; f_valid = 1'b0;
    tick();
    reset = 1'b1;

    // Grant table in IDLE, priority to I after reset.
    tick();
    for (int v = 0; v < 6; v++) begin
      i_valid = vecs[v].iv; f_valid = vecs[v].fv; flush = vecs[v].fl;
      #1;
      chk($sformatf("vec%0d_i_ready", v), i_ready, vecs[v].exp_ir);
      chk($sformatf("vec%0d_f_ready", v), f_ready, vecs[v].exp_fr);
    end
    i_valid = 1'b0; f_valid = 1'b0; flush = 1'b0;

    // I-only divide, done 20 cycles after start.
    tick();
    i_valid = 1'b1; i_tag = 5'd5; i_op = op_a;
    #1 chk("t1_i_ready", i_ready, 1);
    tick();
    i_valid = 1'b0;
    #1;
    chk("t1_start", unit_start, 1);
    chk("t1_isint", unit_isint, 1);
    chk("t1_op", unit_op, op_a);
    unit_busy = 1'b1;
    begin
      logic bad = 1'b0;
      for (int k = 1; k < 20; k++) begin
        tick();
        #1;
        if (unit_start || rsp_valid || i_ready || unit_op !== op_a) bad = 1'b1;
      end
      chk("t1_busy_quiet", bad, 0);
    end
    tick();
    unit_done = 1'b1; unit_busy = 1'b0; unit_result = 72'h2A;
    tick();
    unit_done = 1'b0; unit_result = 72'hFF; rsp_ready = 1'b1;
    #1;
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_tag", rsp_tag, 5);
    chk("t1_rsp_isint", rsp_isint, 1);
    chk("t1_rsp_result", rsp_result, 72'h2A);
    tick();
    rsp_ready = 1'b0;
    i_valid = 1'b1;
    #1;
    chk("t1_rsp_gone", rsp_valid, 0);
    chk("t1_i_ready_again", i_ready, 1);
    i_valid = 1'b0;

    // Both valid from reset: grants alternate I, F, I.
    do_reset();
    tick();
    i_valid = 1'b1; f_valid = 1'b1; i_tag = 5'd3; f_tag = 5'd9;
    for (int g = 0; g < 3; g++) begin
      logic exp_i;
      exp_i = (g != 1);
      #1;
      chk($sformatf("t2_g%0d_i_ready", g), i_ready, exp_i);
      chk($sformatf("t2_g%0d_f_ready", g), f_ready, !exp_i);
      tick();
      #1;
      chk($sformatf("t2_g%0d_start", g), unit_start, 1);
      unit_busy = 1'b1;
      begin
        logic bad = 1'b0;
        for (int k = 1; k < 10; k++) begin
          tick();
          #1;
          if (unit_start || i_ready || f_ready) bad = 1'b1;
        end
        chk($sformatf("t2_g%0d_no_overlap", g), bad, 0);
      end
      tick();
      unit_done = 1'b1; unit_busy = 1'b0; unit_result = RESW'(g + 256);
      tick();
      unit_done = 1'b0; rsp_ready = 1'b1;
      #1;
      chk($sformatf("t2_g%0d_rsp_valid", g), rsp_valid, 1);
      chk($sformatf("t2_g%0d_rsp_tag", g), rsp_tag, exp_i ? 5'd3 : 5'd9);
      chk($sformatf("t2_g%0d_rsp_isint", g), rsp_isint, exp_i);
      chk($sformatf("t2_g%0d_rsp_result", g), rsp_result, RESW'(g + 256));
      tick();
      rsp_ready = 1'b0;
    end
    #1;
    chk("t2_next_is_f", f_ready, 1);
    chk("t2_next_not_i", i_ready, 0);
    i_valid = 1'b0; f_valid = 1'b0;

    // Response backpressure for 7 cycles with F request pending.
    tick();
    f_valid = 1'b1; f_tag = 5'd7; f_op = op_b;
    #1 chk("t3_f_ready", f_ready, 1);
    tick();
    f_valid = 1'b0;
    #1;
    chk("t3_start", unit_start, 1);
    chk("t3_isint", unit_isint, 0);
    unit_busy = 1'b1;
    tick();
    tick();
    unit_done = 1'b1; unit_busy = 1'b0; unit_result = 72'h55;
    tick();
    unit_done = 1'b0; unit_result = 72'hDEAD; f_valid = 1'b1; f_tag = 5'd8;
    for (int k = 0; k < 7; k++) begin
      #1;
      chk($sformatf("t3_hold%0d_valid", k), rsp_valid, 1);
      chk($sformatf("t3_hold%0d_tag", k), rsp_tag, 7);
      chk($sformatf("t3_hold%0d_result", k), rsp_result, 72'h55);
      chk($sformatf("t3_hold%0d_f_ready", k), f_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    #1 chk("t3_accept_valid", rsp_valid, 1);
    tick();
    rsp_ready = 1'b0;
    #1;
    chk("t3_rsp_dropped", rsp_valid, 0);
    chk("t3_f_ready_after", f_ready, 1);
    f_valid = 1'b0;

    // Flush in BUSY together with unit_done.
    tick();
    i_valid = 1'b1; i_tag = 5'd11; i_op = op_c;
    tick();
    i_valid = 1'b0; unit_busy = 1'b1;
    tick();
    tick();
    flush = 1'b1; unit_done = 1'b1; unit_result = 72'h77;
    #1 chk("t4_flush_pulse", unit_flush, 1);
    tick();
    flush = 1'b0; unit_done = 1'b0;
    #1;
    chk("t4_drain_flush", unit_flush, 1);
    chk("t4_no_rsp0", rsp_valid, 0);
    chk("t4_op_held", unit_op, op_c);
    tick();
    unit_done = 1'b1;
    #1;
    chk("t4_drain_flush2", unit_flush, 1);
    chk("t4_no_rsp1", rsp_valid, 0);
    tick();
    unit_done = 1'b0; unit_busy = 1'b0;
    #1 chk("t4_drain_flush3", unit_flush, 1);
    tick();
    i_valid = 1'b1; i_tag = 5'd12; i_op = op_a;
    #1;
    chk("t4_idle_flush_low", unit_flush, 0);
    chk("t4_no_rsp2", rsp_valid, 0);
    chk("t4_i_ready", i_ready, 1);
    tick();
    i_valid = 1'b0;
    #1 chk("t4_next_start", unit_start, 1);
    unit_busy = 1'b1;
    tick();
    unit_done = 1'b1; unit_busy = 1'b0; unit_result = 72'h99;
    tick();
    unit_done = 1'b0; rsp_ready = 1'b1;
    #1;
    chk("t4_next_valid", rsp_valid, 1);
    chk("t4_next_tag", rsp_tag, 12);
    chk("t4_next_result", rsp_result, 72'h99);
    tick();
    rsp_ready = 1'b0;

    // Flush in ISSUE suppresses unit_start.
    f_valid = 1'b1; f_tag = 5'd4;
    tick();
    f_valid = 1'b0; flush = 1'b1;
    #1 chk("t5_start_suppressed", unit_start, 0);
    tick();
    flush = 1'b0;
    #1 chk("t5_back_idle", rsp_valid, 0);

    // Done in the start cycle is captured; flush then drops the response.
    i_valid = 1'b1; i_tag = 5'd13;
    tick();
    i_valid = 1'b0; unit_done = 1'b1; unit_result = 72'h33;
    #1 chk("t6_start", unit_start, 1);
    tick();
    unit_done = 1'b0;
    #1;
    chk("t6_early_valid", rsp_valid, 1);
    chk("t6_early_result", rsp_result, 72'h33);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1 chk("t6_flushed_rsp", rsp_valid, 0);

    // Watchdog on the TOUT=15 instance.
    do_reset();
    tick();
    i_valid = 1'b1; i_tag = 5'd1;
    tick();
    i_valid = 1'b0; unit_busy = 1'b1;
    #1 chk("t7_start", wd_unit_start, 1);
    for (int n = 1; n <= 15; n++) begin
      tick();
      #1;
      chk($sformatf("t7_c%0d_err", n), wd_wdog_err, 0);
      chk($sformatf("t7_c%0d_flush", n), wd_unit_flush, (n == 15));
    end
    tick();
    #1;
    chk("t7_err_set", wd_wdog_err, 1);
    chk("t7_drain_flush", wd_unit_flush, 1);
    chk("t7_main_no_err", wdog_err, 0);
    tick();
    tick();
    unit_busy = 1'b0;
    #1 chk("t7_drain_last", wd_unit_flush, 1);
    tick();
    #1;
    chk("t7_idle_flush_low", wd_unit_flush, 0);
    chk("t7_no_rsp", wd_rsp_valid, 0);
    tick();
    tick();
    #1 chk("t7_err_sticky", wd_wdog_err, 1);

    // Async reset between edges while the main instance is BUSY.
    unit_busy = 1'b1;
    @(posedge clk);
    #3;
    chk("t8_pre_isint", unit_isint, 1);
    reset = 1'b0;
    #1;
    chk("t8_isint_zero", unit_isint, 0);
    chk("t8_op_zero", unit_op, 0);
    chk("t8_wd_err_zero", wd_wdog_err, 0);
    chk("t8_rsp_zero", rsp_valid, 0);
    tick();
    reset = 1'b1; unit_busy = 1'b0;
    tick();
    i_valid = 1'b1; i_tag = 5'd2; i_op = op_b;
    #1 chk("t8_i_ready", i_ready, 1);
    tick();
    i_valid = 1'b0;
    #1;
    chk("t8_start", unit_start, 1);
    chk("t8_op", unit_op, op_b);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
